// File: rtl/top_pkg.sv
// Shared widths and mode encodings for the two-mode
// add / multiply-accumulate datapath.
package top_pkg;
  localparam int W_IN  = 32;
  localparam int W_MUL = 16;
  localparam int W_OUT = 40;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_MAC = 1'b1;
endpackage

// File: rtl/mac40.sv
// 16x16 multiplier feeding a 40-bit wrapping accumulator
// with synchronous clear and asynchronous reset.
module mac40
  import top_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  input  logic [W_MUL-1:0] a,
  input  logic [W_MUL-1:0] b,
  output logic [W_OUT-1:0] acc
);

  logic [2*W_MUL-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + W_OUT'(prod);
    end
  end

endmodule

// File: rtl/top.sv
// Two-stage registered arithmetic unit: 33-bit add or
// 40-bit multiply-accumulate of the low operand halves.
module top
  import top_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic [W_IN-1:0]  A,
  input  logic [W_IN-1:0]  B,
  input  logic             Sel,
  output logic [W_OUT-1:0] Result
);

  logic [W_IN-1:0]  a_q;
  logic [W_IN-1:0]  b_q;
  logic             sel_q;
  logic [W_IN:0]    sum_q;
  logic             mode_q;
  logic [W_OUT-1:0] acc;

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= MODE_ADD;
      sum_q  <= '0;
      mode_q <= MODE_ADD;
    end else begin
      a_q    <= A;
      b_q    <= B;
      sel_q  <= Sel;
      sum_q  <= {1'b0, a_q} + {1'b0, b_q};
      mode_q <= sel_q;
    end
  end

  // acc is the stage-2 register in MAC mode; the add
  // sum is its stage-2 peer, so both sides are flops.
  mac40 u_mac (
    .clk  (clk),
    .nRST (nRST),
    .clr  (sel_q == MODE_ADD),
    .en   (sel_q == MODE_MAC),
    .a    (a_q[W_MUL-1:0]),
    .b    (b_q[W_MUL-1:0]),
    .acc  (acc)
  );

  assign Result = (mode_q == MODE_MAC) ? acc
                                       : W_OUT'(sum_q);

endmodule

// File: tb/tb_top.sv
// Randomized and directed bench for top against a
// behavioural add / MAC reference model.
module tb_top;

  logic        clk;
  logic        nRST;
  logic [31:0] A;
  logic [31:0] B;
  logic        Sel;
  logic [39:0] Result;

  int passed;
  int total;

  // reference model: inputs seen at last edge, accumulator
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sel;
  longint unsigned m_acc;
  logic [39:0] m_res;

  localparam longint unsigned MASK40 = 64'h00FF_FFFF_FFFF;

  top dut (
    .clk    (clk),
    .nRST   (nRST),
    .A      (A),
    .B      (B),
    .Sel    (Sel),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_zero();
    m_a   = '0;
    m_b   = '0;
    m_sel = 1'b0;
    m_acc = 0;
    m_res = '0;
  endtask

  task automatic tick();
    longint unsigned p;
    @(posedge clk);
    if (nRST) begin
      model_zero();
    end else begin
      if (m_sel) begin
        p = longint'(m_a[15:0]) * longint'(m_b[15:0]);
        m_acc = (m_acc + p) & MASK40;
        m_res = m_acc[39:0];
      end else begin
        m_acc = 0;
        m_res = 40'(longint'(m_a) + longint'(m_b));
      end
      m_a   = A;
      m_b   = B;
      m_sel = Sel;
    end
    #1;
  endtask

  task automatic test_reset();
    A    = $urandom;
    B    = $urandom;
    Sel  = 1'($urandom);
    nRST = 1'b1;
    model_zero();
    #1;
    total++;
    if (Result !== 40'd0)
      $display("FAIL reset_async: got %h want 0", Result);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      A   = $urandom;
      B   = $urandom;
      Sel = 1'($urandom);
      tick();
      total++;
      if (Result !== 40'd0)
        $display("FAIL reset_hold: got %h want 0", Result);
      else passed++;
    end
    nRST = 1'b0;
  endtask

  task automatic test_add();
    Sel = 1'b0;
    A   = 32'd10;
    B   = 32'd20;
    tick();
    tick();
    total++;
    if (Result !== 40'd30)
      $display("FAIL add_basic: got %0d want 30", Result);
    else passed++;
    tick();
    total++;
    if (Result !== 40'd30 || Result !== m_res)
      $display("FAIL add_hold: got %0d want 30", Result);
    else passed++;
  endtask

  task automatic test_add_width();
    Sel = 1'b0;
    A   = 32'hFFFF_FFFF;
    B   = 32'hFFFF_FFFF;
    tick();
    tick();
    total++;
    if (Result !== 40'h01_FFFF_FFFE)
      $display("FAIL add_width: got %h want 01fffffffe",
               Result);
    else passed++;
  endtask

  task automatic test_mac_accum();
    logic [39:0] want;
    Sel = 1'b1;
    A   = 32'd99;
    B   = 32'd2;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = 40'(198 * i);
      total++;
      if (Result !== want || Result !== m_res)
        $display("FAIL mac_99x2[%0d]: got %0d want %0d",
                 i, Result, want);
      else passed++;
    end
    A = 32'd80;
    B = 32'd90;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = 40'(198 * 5 + 7200 * i);
      total++;
      if (Result !== want || Result !== m_res)
        $display("FAIL mac_80x90[%0d]: got %0d want %0d",
                 i, Result, want);
      else passed++;
    end
  endtask

  task automatic test_mac_wrap();
    logic [39:0] prev;
    logic [39:0] step;
    bit wrapped;
    wrapped = 1'b0;
    Sel = 1'b0;
    A   = 32'd0;
    B   = 32'd0;
    tick();
    Sel = 1'b1;
    A   = 32'hABCD_FFFF;
    B   = 32'hABCD_FFFF;
    tick();
    tick();
    prev = Result;
    total++;
    if (Result !== 40'h00_FFFE_0001)
      $display("FAIL mac_first_step: got %h want fffe0001",
               Result);
    else passed++;
    for (int i = 0; i < 270; i++) begin
      tick();
      step = Result - prev;
      if (Result < prev) wrapped = 1'b1;
      total++;
      if (step !== 40'h00_FFFE_0001 || Result !== m_res)
        $display("FAIL mac_wrap_step[%0d]: got %h want %h",
                 i, Result, m_res);
      else passed++;
      prev = Result;
    end
    total++;
    if (!wrapped)
      $display("FAIL mac_wrap_seen: got %0d want 1", wrapped);
    else passed++;
  endtask

  task automatic test_mode_switch();
    Sel = 1'b1;
    A   = 32'd5;
    B   = 32'd7;
    repeat (4) tick();
    Sel = 1'b0;
    A   = 32'd1;
    B   = 32'd1;
    tick();
    Sel = 1'b1;
    A   = 32'd3;
    B   = 32'd4;
    tick();
    total++;
    if (Result !== 40'd2 || Result !== m_res)
      $display("FAIL switch_add: got %0d want 2", Result);
    else passed++;
    tick();
    total++;
    if (Result !== 40'd12)
      $display("FAIL switch_restart: got %0d want 12", Result);
    else passed++;
    tick();
    total++;
    if (Result !== 40'd24)
      $display("FAIL switch_next: got %0d want 24", Result);
    else passed++;
  endtask

  task automatic test_reset_mid_mac();
    Sel = 1'b1;
    A   = 32'd3;
    B   = 32'd4;
    repeat (3) tick();
    nRST = 1'b1;
    model_zero();
    #1;
    total++;
    if (Result !== 40'd0)
      $display("FAIL midreset_async: got %0d want 0", Result);
    else passed++;
    tick();
    nRST = 1'b0;
    tick();
    tick();
    total++;
    if (Result !== 40'd12 || Result !== m_res)
      $display("FAIL midreset_resume: got %0d want 12",
               Result);
    else passed++;
    tick();
    total++;
    if (Result !== 40'd24)
      $display("FAIL midreset_next: got %0d want 24", Result);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      A   = $urandom;
      B   = $urandom;
      Sel = ($urandom_range(0, 3) != 0);
      tick();
      total++;
      if (Result !== m_res)
        $display("FAIL random[%0d]: got %h want %h",
                 i, Result, m_res);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    nRST   = 1'b0;
    A      = '0;
    B      = '0;
    Sel    = 1'b0;
    #2;
    test_reset();
    test_add();
    test_add_width();
    test_mac_accum();
    test_mac_wrap();
    test_mode_switch();
    test_reset_mid_mac();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
